// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants, the HI/LO timer state type
// and the per-operand hazard test.
package pipe_pkg;
    localparam int TW = 2;
    localparam logic [TW-1:0] TUSE_NONE = 2'd3;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    typedef logic [TW-1:0] tval_t;
    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
    // A producer blocks a consumer only if its result arrives after the consumer needs it.
    function automatic logic src_hazard(input logic [4:0] src, input tval_t tuse,
                                        input logic [4:0] wa, input tval_t tnew);
        return (src != 5'd0) && (src == wa) && (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction
endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: counts down the busy window of the HI/LO unit after a
// mult/div start; starts arriving while busy are ignored.
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_div,
    output logic       o_busy,
    output logic [3:0] o_cnt
);
    md_state_t  r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == MD_IDLE) begin
            if (i_start) begin
                w_state_nxt = MD_BUSY;
                w_cnt_nxt   = i_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end
        end else begin
            w_cnt_nxt   = r_cnt - 4'd1;
            w_state_nxt = (r_cnt == 4'd1) ? MD_IDLE : MD_BUSY;
        end
    end

    assign o_busy = (r_cnt != 4'd0);
    assign o_cnt  = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush generation from D-stage operand timing against
// E/M producers and the HI/LO busy window, plus a saturating stall counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_d_rs,
    input  logic [4:0]  i_d_rt,
    input  tval_t       i_d_tuse_rs,
    input  tval_t       i_d_tuse_rt,
    input  logic [4:0]  i_e_wa,
    input  logic [4:0]  i_m_wa,
    input  tval_t       i_e_tnew,
    input  tval_t       i_m_tnew,
    input  logic        i_d_md_use,
    input  logic        i_e_md_start,
    input  logic        i_e_md_div,
    output logic        o_stall,
    output logic        o_flush_e,
    output logic        o_md_busy,
    output logic [3:0]  o_md_cnt,
    output logic [31:0] o_stall_cycles
);
    logic        w_data_hz, w_md_stall, w_md_busy;
    logic [31:0] r_stall_cycles;

    md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_e_md_start),
        .i_div   (i_e_md_div),
        .o_busy  (w_md_busy),
        .o_cnt   (o_md_cnt)
    );

    assign w_data_hz = src_hazard(i_d_rs, i_d_tuse_rs, i_e_wa, i_e_tnew)
                     | src_hazard(i_d_rs, i_d_tuse_rs, i_m_wa, i_m_tnew)
                     | src_hazard(i_d_rt, i_d_tuse_rt, i_e_wa, i_e_tnew)
                     | src_hazard(i_d_rt, i_d_tuse_rt, i_m_wa, i_m_tnew);
    // A start in E makes the unit busy next cycle, so the HI/LO consumer must hold now.
    assign w_md_stall = i_d_md_use & (w_md_busy | i_e_md_start);
    assign o_stall    = w_data_hz | w_md_stall;
    assign o_flush_e  = o_stall;
    assign o_md_busy  = w_md_busy;

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cycles <= '0;
        else if (o_stall && !(&r_stall_cycles))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign o_stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with a cycle-indexed behavioural model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  d_rs, d_rt, e_wa, m_wa;
    logic [1:0]  tuse_rs, tuse_rt, e_tnew, m_tnew;
    logic        md_use, md_start, md_div;
    logic        stall, flush_e, md_busy;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cycles;

    int     n_chk = 0, n_err = 0;
    bit     run = 1'b0, sc_model_on = 1'b1;
    int     cyc = 0, md_end = 0;
    longint m_sc = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .i_d_rs         (d_rs),
        .i_d_rt         (d_rt),
        .i_d_tuse_rs    (tuse_rs),
        .i_d_tuse_rt    (tuse_rt),
        .i_e_wa         (e_wa),
        .i_m_wa         (m_wa),
        .i_e_tnew       (e_tnew),
        .i_m_tnew       (m_tnew),
        .i_d_md_use     (md_use),
        .i_e_md_start   (md_start),
        .i_e_md_div     (md_div),
        .o_stall        (stall),
        .o_flush_e      (flush_e),
        .o_md_busy      (md_busy),
        .o_md_cnt       (md_cnt),
        .o_stall_cycles (stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit src_hz(input logic [4:0] src, input logic [1:0] tu);
        if (src == 5'd0 || tu == 2'd3) return 1'b0;
        return (src == e_wa && tu < e_tnew) || (src == m_wa && tu < m_tnew);
    endfunction

    // Remaining busy cycles in the current cycle, from the recorded end cycle.
    function automatic int mcnt();
        return (md_end > cyc) ? md_end - cyc : 0;
    endfunction

    function automatic bit exp_stall();
        return src_hz(d_rs, tuse_rs) || src_hz(d_rt, tuse_rt) || (md_use && (mcnt() != 0 || md_start));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            md_end <= 0;
            m_sc   <= 0;
        end else begin
            if (exp_stall() && m_sc < 64'hFFFF_FFFF) m_sc <= m_sc + 1;
            if (md_start && mcnt() == 0) md_end <= cyc + (md_div ? 10 : 5) + 1;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (run) begin
            chk("model stall", 32'(stall), 32'(exp_stall()));
            chk("model flush_e", 32'(flush_e), 32'(exp_stall()));
            chk("model md_cnt", 32'(md_cnt), 32'(mcnt()));
            chk("model md_busy", 32'(md_busy), 32'(mcnt() != 0));
            if (sc_model_on) chk("model stall_cycles", stall_cycles, m_sc[31:0]);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_in();
        d_rs = 0; d_rt = 0; tuse_rs = 2'd3; tuse_rt = 2'd3;
        e_wa = 0; m_wa = 0; e_tnew = 0; m_tnew = 0;
        md_use = 0; md_start = 0; md_div = 0;
    endtask

    task automatic mult_seq(input string tag);
        logic [31:0] s0;
        idle_in(); md_use = 1; md_start = 1; md_div = 0;
        settle();
        s0 = stall_cycles;
        chk({tag, " start stall"}, 32'(stall), 1);
        next(); md_start = 0;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk({tag, " md_cnt"}, 32'(md_cnt), 32'(5 - k));
            chk({tag, " stall"}, 32'(stall), 32'(k < 5));
            if (k < 5) next();
        end
        chk({tag, " stall_cycles"}, stall_cycles, s0 + 32'd6);
        next(); idle_in();
    endtask

    initial begin
        logic [31:0] s0;
        idle_in();
        next(); next();
        run = 1'b1;
        settle();
        chk("reset md_cnt", 32'(md_cnt), 0);
        chk("reset stall_cycles", stall_cycles, 0);
        chk("reset md_busy", 32'(md_busy), 0);
        next(); reset = 1'b0;

        d_rs = 8; tuse_rs = 1; e_wa = 8; e_tnew = 2;
        settle();
        chk("loaduse E stall", 32'(stall), 1);
        chk("loaduse E flush_e", 32'(flush_e), 1);
        next(); e_wa = 0; e_tnew = 0; m_wa = 8; m_tnew = 1; tuse_rs = 0;
        settle(); chk("loaduse M stall", 32'(stall), 1);
        next(); m_tnew = 0;
        settle(); chk("loaduse clear", 32'(stall), 0);
        next(); tuse_rs = 1; m_tnew = 1;
        settle(); chk("tuse equals tnew", 32'(stall), 0);

        next(); idle_in(); tuse_rs = 0; e_tnew = 2;
        settle(); chk("reg zero", 32'(stall), 0);
        next(); idle_in(); d_rt = 9; tuse_rt = 3; e_wa = 9; e_tnew = 3;
        settle(); chk("tuse none", 32'(stall), 0);

        next(); idle_in(); d_rs = 3; tuse_rs = 0; e_wa = 3; e_tnew = 1;
        d_rt = 4; tuse_rt = 0; m_wa = 4; m_tnew = 1;
        settle(); s0 = stall_cycles; chk("E and M stall", 32'(stall), 1);
        next(); idle_in();
        settle(); chk("E and M counted once", stall_cycles, s0 + 32'd1);

        next(); mult_seq("mult");

        md_start = 1;
        settle();
        next(); md_start = 0; md_use = 1; d_rs = 6; tuse_rs = 0; e_wa = 6; e_tnew = 1;
        settle(); s0 = stall_cycles; chk("data+md stall", 32'(stall), 1);
        next(); idle_in();
        settle(); chk("data+md counted once", stall_cycles, s0 + 32'd1);
        for (int k = 0; k < 5; k++) next();

        md_start = 1; md_div = 1;
        settle();
        next(); md_start = 0;
        for (int k = 0; k <= 10; k++) begin
            md_start = (k == 2);
            settle();
            chk("div md_cnt", 32'(md_cnt), 32'(10 - k));
            chk("div md_busy", 32'(md_busy), 32'(k < 10));
            next();
        end
        idle_in();

        md_start = 1; md_div = 1;
        settle();
        next(); md_start = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) reset = 1'b1;
            settle();
            chk("div before reset md_cnt", 32'(md_cnt), 32'(10 - k));
            next();
        end
        reset = 1'b0;
        settle();
        chk("abort md_cnt", 32'(md_cnt), 0);
        chk("abort md_busy", 32'(md_busy), 0);
        chk("abort stall_cycles", stall_cycles, 0);
        next(); mult_seq("mult after reset");

        sc_model_on = 1'b0;
        #1 force dut.r_stall_cycles = 32'hFFFF_FFFE;
        settle(); chk("deposit", stall_cycles, 32'hFFFF_FFFE);
        next(); release dut.r_stall_cycles;
        settle(); chk("deposit kept", stall_cycles, 32'hFFFF_FFFE);
        next(); d_rs = 5; tuse_rs = 0; e_wa = 5; e_tnew = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            if (k > 0) chk("saturate", stall_cycles, 32'hFFFF_FFFF);
            next();
        end
        settle(); chk("saturate after 3", stall_cycles, 32'hFFFF_FFFF);
        next(); idle_in();
        settle(); chk("saturate hold", stall_cycles, 32'hFFFF_FFFF);
        next();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
